// File: rtl/mult_fu_pool_pkg.sv
// Shared types and defaults for the multiplier pool: function encoding,
// lane state encoding and operand signedness helpers.
package mult_fu_pool_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_e;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_BUSY = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  localparam int NUM_FU_MULT = 2;
  localparam int MULT_STAGES = 4;

  function automatic logic rs1_signed(mult_func_e f);
    return f != MULHU;
  endfunction

  function automatic logic rs2_signed(mult_func_e f);
    return (f == MUL) || (f == MULH);
  endfunction

endpackage

// File: rtl/mult_fu_pool_lane.sv
// One iterative multiplier lane: captures an op, accumulates BITS multiplier
// bits per cycle, then holds the result until the pool grants it.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   LANE_IDLE | free, accepts i_start
//   LANE_BUSY | shift-add in progress, r_cnt counts down
//   LANE_DONE | result held until i_grant
module mult_fu_pool_lane
  import mult_fu_pool_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = MULT_STAGES,
  parameter int TAG_W      = 6
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_func,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_grant,
  input  logic             i_squash,
  output logic             o_free,
  output logic             o_done,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int PW    = 2 * XLEN;
  localparam int BITS  = PW / NUM_STAGES;
  localparam int CNT_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  lane_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand, r_mplier, r_acc, w_chunk;
  logic             r_is_mul;
  logic [TAG_W-1:0] r_tag;
  logic             w_s1, w_s2, w_capture;

  assign w_s1      = rs1_signed(mult_func_e'(i_func));
  assign w_s2      = rs2_signed(mult_func_e'(i_func));
  assign w_capture = (r_state == LANE_IDLE) && i_start && !i_squash;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= LANE_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LANE_IDLE: if (i_start)      w_state_nxt = LANE_BUSY;
      LANE_BUSY: if (r_cnt == '0)  w_state_nxt = LANE_DONE;
      LANE_DONE: if (i_grant)      w_state_nxt = LANE_IDLE;
      default:                     w_state_nxt = LANE_IDLE;
    endcase
    if (i_squash) w_state_nxt = LANE_IDLE;
  end

  // Multiplier chunks are taken unsigned; signedness lives in the 2*XLEN extension.
  always_comb begin
    w_chunk            = '0;
    w_chunk[BITS-1:0]  = r_mplier[BITS-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_is_mul <= 1'b0;
      r_tag    <= '0;
    end else if (w_capture) begin
      r_mcand  <= {{XLEN{w_s1 & i_rs1[XLEN-1]}}, i_rs1};
      r_mplier <= {{XLEN{w_s2 & i_rs2[XLEN-1]}}, i_rs2};
      r_acc    <= '0;
      r_cnt    <= CNT_W'(NUM_STAGES - 1);
      r_is_mul <= (mult_func_e'(i_func) == MUL);
      r_tag    <= i_tag;
    end else if (r_state == LANE_BUSY) begin
      r_acc    <= r_acc + (r_mcand * w_chunk);
      r_mcand  <= r_mcand << BITS;
      r_mplier <= r_mplier >> BITS;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign o_free   = (r_state == LANE_IDLE);
  assign o_done   = (r_state == LANE_DONE);
  assign o_result = r_is_mul ? r_acc[XLEN-1:0] : r_acc[PW-1:XLEN];
  assign o_tag    = r_tag;

endmodule

// File: rtl/mult_fu_pool.sv
// Pool of iterative multiplier lanes with a round-robin completion port.
// Squash flushes every lane and freezes the round-robin pointer.
module mult_fu_pool
  import mult_fu_pool_pkg::*;
#(
  parameter int NUM_MULT   = NUM_FU_MULT,
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = MULT_STAGES,
  parameter int TAG_W      = 6,
  parameter int IDX_W      = (NUM_MULT > 1) ? $clog2(NUM_MULT) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_issue_valid,
  input  logic [IDX_W-1:0]    i_issue_idx,
  input  logic [1:0]          i_issue_func,
  input  logic [XLEN-1:0]     i_issue_rs1,
  input  logic [XLEN-1:0]     i_issue_rs2,
  input  logic [TAG_W-1:0]    i_issue_tag,
  input  logic                i_squash,
  output logic [NUM_MULT-1:0] o_free,
  output logic                o_done_valid,
  output logic [XLEN-1:0]     o_done_result,
  output logic [TAG_W-1:0]    o_done_tag,
  output logic [IDX_W-1:0]    o_done_idx,
  input  logic                i_done_ready
);

  logic [NUM_MULT-1:0] w_free, w_done, w_start, w_grant;
  logic [XLEN-1:0]     w_res [NUM_MULT];
  logic [TAG_W-1:0]    w_tag [NUM_MULT];
  logic [IDX_W-1:0]    r_ptr, w_gnt_idx;
  logic                w_any, w_xfer;

  for (genvar g = 0; g < NUM_MULT; g++) begin : g_lane
    assign w_start[g] = i_issue_valid && (i_issue_idx == IDX_W'(g)) && !i_squash;
    assign w_grant[g] = w_xfer && (w_gnt_idx == IDX_W'(g));

    mult_fu_pool_lane #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES),
      .TAG_W      (TAG_W)
    ) u_lane (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_start  (w_start[g]),
      .i_func   (i_issue_func),
      .i_rs1    (i_issue_rs1),
      .i_rs2    (i_issue_rs2),
      .i_tag    (i_issue_tag),
      .i_grant  (w_grant[g]),
      .i_squash (i_squash),
      .o_free   (w_free[g]),
      .o_done   (w_done[g]),
      .o_result (w_res[g]),
      .o_tag    (w_tag[g])
    );
  end

  // Round robin: first DONE lane at or above the pointer, else wrap to the lowest.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      if (!w_any && w_done[i] && (IDX_W'(i) >= r_ptr)) begin
        w_any     = 1'b1;
        w_gnt_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MULT; i++) begin
      if (!w_any && w_done[i]) begin
        w_any     = 1'b1;
        w_gnt_idx = IDX_W'(i);
      end
    end
  end

  assign w_xfer = w_any && i_done_ready;

  always_comb begin
    o_done_result = '0;
    o_done_tag    = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      if (w_any && (w_gnt_idx == IDX_W'(i))) begin
        o_done_result = w_res[i];
        o_done_tag    = w_tag[i];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (w_xfer && !i_squash) begin
      r_ptr <= (w_gnt_idx == IDX_W'(NUM_MULT - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end

  assign o_free       = w_free;
  assign o_done_valid = w_any;
  assign o_done_idx   = w_any ? w_gnt_idx : '0;

  // Issue into a busy lane is dropped by the lane itself; flag it in simulation.
  always_ff @(posedge i_clock) begin
    if (i_reset && i_issue_valid && !i_squash)
      assert ((int'(i_issue_idx) < NUM_MULT) && w_free[i_issue_idx])
        else $error("mult_fu_pool: issue to non-free lane %0d", i_issue_idx);
  end

endmodule
